// File: rtl/wrf_pkg.sv
// WR-fabric sink shared definitions.
// Fabric address map, LFSR taps and the captured beat bundle.
package wrf_pkg;

    localparam logic [1:0] c_WRF_DATA   = 2'd0;
    localparam logic [1:0] c_WRF_OOB    = 2'd1;
    localparam logic [1:0] c_WRF_STATUS = 2'd2;
    localparam logic [1:0] c_WRF_USER   = 2'd3;

    // Right-shift Galois mask for x^16+x^14+x^13+x^11+1
    localparam logic [15:0] c_LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic [1:0]  adr;
        logic [1:0]  sel;
        logic [15:0] dat;
        logic        sof;
    } wrf_beat_t;

endpackage

// File: rtl/wrf_stall_sink_if.sv
// Pipelined Wishbone fabric bus between a source and the sink.
// Signal suffixes are as seen from the sink.
interface wrf_stall_sink_if;

    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [1:0]  sel_i;
    logic [1:0]  adr_i;
    logic [15:0] dat_i;
    logic        ack_o;
    logic        err_o;
    logic        stall_o;

    modport master (
        output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        input  ack_o, err_o, stall_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        output ack_o, err_o, stall_o
    );

endinterface

// File: rtl/wrf_stall_gen.sv
// Pseudo-random stall source: free-running LFSR,
// probability threshold and a consecutive-run limiter.
module wrf_stall_gen
    import wrf_pkg::*;
#(
    parameter logic [15:0] g_lfsr_seed     = 16'hACE1,
    parameter int unsigned g_max_stall_run = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       en_i,
    input  logic [7:0] thresh_i,
    output logic       rand_stall_o
);

    localparam logic [3:0] c_MAX_RUN = 4'(g_max_stall_run);

    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  run_q, run_d;
    logic        rand_stall_q, rand_stall_d;

    // Next LFSR value, stall decision and run length
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ c_LFSR_TAPS;
        end
        rand_stall_d = en_i
                     & (lfsr_q[7:0] < thresh_i)
                     & (run_q < c_MAX_RUN);
        run_d = 4'd0;
        if (rand_stall_d) begin
            run_d = (run_q == c_MAX_RUN) ? run_q : run_q + 4'd1;
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lfsr_q       <= g_lfsr_seed;
            run_q        <= 4'd0;
            rand_stall_q <= 1'b0;
        end else begin
            lfsr_q       <= lfsr_d;
            run_q        <= run_d;
            rand_stall_q <= rand_stall_d;
        end
    end

    assign rand_stall_o = rand_stall_q;

endmodule

// File: rtl/wrf_stall_sink.sv
// WR-fabric sink endpoint with random throttling,
// one-deep registered stream output and frame accounting.
module wrf_stall_sink
    import wrf_pkg::*;
#(
    parameter logic [15:0] g_lfsr_seed     = 16'hACE1,
    parameter int unsigned g_max_stall_run = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    wrf_stall_sink_if.slave snk,
    input  logic        stall_en_i,
    input  logic [7:0]  stall_thresh_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [1:0]  out_adr_o,
    output logic [1:0]  out_sel_o,
    output logic [15:0] out_dat_o,
    output logic        out_sof_o,
    output logic        eof_o,
    output logic [15:0] last_beats_o,
    output logic [31:0] frame_cnt_o
);

    logic rand_stall, hold_stall;
    logic accept, wr_acc, rd_acc;
    logic cyc_rise, cyc_fall;

    wrf_beat_t   beat_q, beat_d;
    logic        valid_q, valid_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        cyc_q, cyc_d;
    logic        sof_pend_q, sof_pend_d;
    logic        eof_q, eof_d;
    logic [15:0] beat_cnt_q, beat_cnt_d;
    logic [15:0] last_beats_q, last_beats_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;

    wrf_stall_gen #(
        .g_lfsr_seed     (g_lfsr_seed),
        .g_max_stall_run (g_max_stall_run)
    ) u_stall_gen (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .en_i         (stall_en_i),
        .thresh_i     (stall_thresh_i),
        .rand_stall_o (rand_stall)
    );

    assign hold_stall  = valid_q & ~out_ready_i;
    assign snk.stall_o = hold_stall | rand_stall;
    assign accept      = snk.cyc_i & snk.stb_i & ~snk.stall_o;
    assign wr_acc      = accept & snk.we_i;
    assign rd_acc      = accept & ~snk.we_i;
    assign cyc_rise    = snk.cyc_i & ~cyc_q;
    assign cyc_fall    = ~snk.cyc_i & cyc_q;

    // Beat capture, handshake replies and frame accounting
    always_comb begin
        beat_d       = beat_q;
        valid_d      = valid_q;
        ack_d        = wr_acc;
        err_d        = rd_acc;
        cyc_d        = snk.cyc_i;
        eof_d        = cyc_fall;
        beat_cnt_d   = beat_cnt_q;
        last_beats_d = last_beats_q;
        frame_cnt_d  = frame_cnt_q;
        sof_pend_d   = (sof_pend_q | cyc_rise) & ~wr_acc & ~cyc_fall;

        if (wr_acc) begin
            beat_d.adr = snk.adr_i;
            beat_d.sel = snk.sel_i;
            beat_d.dat = snk.dat_i;
            beat_d.sof = sof_pend_q | cyc_rise;
            valid_d    = 1'b1;
        end else if (valid_q & out_ready_i) begin
            valid_d = 1'b0;
        end

        if (cyc_fall) begin
            beat_cnt_d   = 16'd0;
            last_beats_d = beat_cnt_q;
            frame_cnt_d  = frame_cnt_q + 32'd1;
        end else if (wr_acc && beat_cnt_q != 16'hFFFF) begin
            beat_cnt_d = beat_cnt_q + 16'd1;
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            beat_q       <= '0;
            valid_q      <= 1'b0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            cyc_q        <= 1'b0;
            sof_pend_q   <= 1'b0;
            eof_q        <= 1'b0;
            beat_cnt_q   <= 16'd0;
            last_beats_q <= 16'd0;
            frame_cnt_q  <= 32'd0;
        end else begin
            beat_q       <= beat_d;
            valid_q      <= valid_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            cyc_q        <= cyc_d;
            sof_pend_q   <= sof_pend_d;
            eof_q        <= eof_d;
            beat_cnt_q   <= beat_cnt_d;
            last_beats_q <= last_beats_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign snk.ack_o    = ack_q;
    assign snk.err_o    = err_q;
    assign out_valid_o  = valid_q;
    assign out_adr_o    = beat_q.adr;
    assign out_sel_o    = beat_q.sel;
    assign out_dat_o    = beat_q.dat;
    assign out_sof_o    = beat_q.sof;
    assign eof_o        = eof_q;
    assign last_beats_o = last_beats_q;
    assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_wrf_stall_sink.sv
// Randomized bench for wrf_stall_sink against a
// queue-based model of the frame and beat stream.
module tb_wrf_stall_sink;
    import wrf_pkg::*;

    typedef struct packed {
        logic [1:0]  adr;
        logic [1:0]  sel;
        logic [15:0] dat;
        logic        sof;
    } tb_beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_en = 1'b0;
    logic [7:0]  stall_thresh = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_adr, out_sel;
    logic [15:0] out_dat;
    logic        out_sof, eof;
    logic [15:0] last_beats;
    logic [31:0] frame_cnt;

    wrf_stall_sink_if snk();

    wrf_stall_sink #(
        .g_lfsr_seed     (16'hACE1),
        .g_max_stall_run (4)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .snk            (snk),
        .stall_en_i     (stall_en),
        .stall_thresh_i (stall_thresh),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_adr_o      (out_adr),
        .out_sel_o      (out_sel),
        .out_dat_o      (out_dat),
        .out_sof_o      (out_sof),
        .eof_o          (eof),
        .last_beats_o   (last_beats),
        .frame_cnt_o    (frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    tb_beat_t exp_q[$];
    tb_beat_t rx_q[$];
    int  ack_cnt = 0, err_cnt = 0, eof_cnt = 0;
    int  lat_errs = 0, to_errs = 0, stall_cyc = 0;
    int  cur_run = 0, max_run = 0, rand_cyc = 0;
    bit  acc_wr_prev = 0, acc_rd_prev = 0;
    bit  first_wr = 0;
    int  exp_frames = 0;
    int  exp_beats = 0;
    bit  rand_ready_en = 0;

    // Bus observer: reply latency, stream capture, stall runs
    always @(negedge clk) begin
        if (!rst_n) begin
            acc_wr_prev = 0;
            acc_rd_prev = 0;
            cur_run = 0;
        end else begin
            if (snk.ack_o !== acc_wr_prev) lat_errs++;
            if (snk.err_o !== acc_rd_prev) lat_errs++;
            if (snk.ack_o === 1'b1) ack_cnt++;
            if (snk.err_o === 1'b1) err_cnt++;
            if (eof === 1'b1) eof_cnt++;
            if (out_valid && out_ready)
                rx_q.push_back('{out_adr, out_sel, out_dat, out_sof});
            if (snk.stall_o) stall_cyc++;
            if (snk.stall_o && !(out_valid && !out_ready)) begin
                cur_run++;
                rand_cyc++;
                if (cur_run > max_run) max_run = cur_run;
            end else begin
                cur_run = 0;
            end
            acc_wr_prev = snk.cyc_i && snk.stb_i && !snk.stall_o && snk.we_i;
            acc_rd_prev = snk.cyc_i && snk.stb_i && !snk.stall_o && !snk.we_i;
        end
    end

    // Random downstream readiness when enabled
    always @(posedge clk) begin
        if (rand_ready_en) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    function automatic int stream_diffs();
        int d = 0;
        if (rx_q.size() != exp_q.size()) d++;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            if (rx_q[i] !== exp_q[i]) d++;
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic open_frame();
        snk.cyc_i = 1'b1;
        first_wr = 1;
        exp_beats = 0;
    endtask

    task automatic drive_beat(input logic we, input logic [1:0] adr,
                              input logic [1:0] sel, input logic [15:0] dat);
        bit ok = 0;
        snk.stb_i = 1'b1;
        snk.we_i  = we;
        snk.adr_i = adr;
        snk.sel_i = sel;
        snk.dat_i = dat;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (!snk.stall_o) ok = 1;
            tick();
            if (ok) break;
        end
        snk.stb_i = 1'b0;
        if (!ok) to_errs++;
        if (ok && we) begin
            exp_q.push_back('{adr, sel, dat, first_wr});
            first_wr = 0;
            exp_beats++;
        end
    endtask

    task automatic close_frame(output bit early, output bit on_time,
                               output logic [15:0] lb, output logic [31:0] fc);
        snk.cyc_i = 1'b0;
        snk.stb_i = 1'b0;
        @(negedge clk);
        early = eof;
        @(negedge clk);
        on_time = eof;
        lb = last_beats;
        fc = frame_cnt;
        exp_frames++;
        tick();
        tick();
    endtask

    task automatic flush();
        out_ready = 1'b1;
        repeat (4) tick();
    endtask

    task automatic rand_write();
        drive_beat(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   16'($urandom));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", out_valid); end
        checks++; if (snk.ack_o !== 1'b0 || snk.err_o !== 1'b0) begin failures++; $display("FAIL rst_ackerr got=%0b%0b exp=00", snk.ack_o, snk.err_o); end
        checks++; if (snk.stall_o !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0b exp=0", snk.stall_o); end
        checks++; if (eof !== 1'b0 || last_beats !== 16'd0 || frame_cnt !== 32'd0) begin failures++; $display("FAIL rst_counters got eof=%0b lb=%0d fc=%0d exp 0/0/0", eof, last_beats, frame_cnt); end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        int a0, s0, l0, e0, t0;
        bit early, on_time;
        logic [15:0] lb;
        logic [31:0] fc;
        stall_en = 1'b0; out_ready = 1'b1;
        exp_q.delete(); rx_q.delete();
        a0 = ack_cnt; s0 = stall_cyc; l0 = lat_errs; e0 = eof_cnt; t0 = to_errs;
        open_frame();
        for (int i = 0; i < 32; i++) rand_write();
        close_frame(early, on_time, lb, fc);
        flush();
        checks++; if (ack_cnt - a0 != 32) begin failures++; $display("FAIL b2b_acks got=%0d exp=32", ack_cnt - a0); end
        checks++; if (stall_cyc != s0) begin failures++; $display("FAIL b2b_stall got=%0d exp=0", stall_cyc - s0); end
        checks++; if (lat_errs != l0 || to_errs != t0) begin failures++; $display("FAIL b2b_latency got=%0d exp=0", lat_errs - l0 + to_errs - t0); end
        checks++; if (stream_diffs() != 0) begin failures++; $display("FAIL b2b_stream got=%0d beats exp=%0d", rx_q.size(), exp_q.size()); end
        checks++; if (early !== 1'b0 || on_time !== 1'b1) begin failures++; $display("FAIL b2b_eof_timing got=%0b%0b exp=01", early, on_time); end
        checks++; if (lb !== 16'd32) begin failures++; $display("FAIL b2b_last_beats got=%0d exp=32", lb); end
        checks++; if (fc !== 32'(exp_frames)) begin failures++; $display("FAIL b2b_frame_cnt got=%0d exp=%0d", fc, exp_frames); end
        checks++; if (eof_cnt - e0 != 1) begin failures++; $display("FAIL b2b_eof_count got=%0d exp=1", eof_cnt - e0); end
    endtask

    task automatic test_random_stall();
        int a0, l0, s0, t0;
        bit early, on_time;
        logic [15:0] lb;
        logic [31:0] fc;
        out_ready = 1'b1;
        stall_en = 1'b1; stall_thresh = 8'd0;
        s0 = stall_cyc;
        repeat (20) tick();
        checks++; if (stall_cyc != s0) begin failures++; $display("FAIL thresh0_stall got=%0d exp=0", stall_cyc - s0); end
        stall_thresh = 8'd255;
        exp_q.delete(); rx_q.delete();
        max_run = 0; cur_run = 0; rand_cyc = 0;
        a0 = ack_cnt; l0 = lat_errs; t0 = to_errs;
        open_frame();
        for (int i = 0; i < 100; i++) rand_write();
        close_frame(early, on_time, lb, fc);
        stall_en = 1'b0;
        flush();
        checks++; if (max_run > 4) begin failures++; $display("FAIL stall_run got=%0d exp<=4", max_run); end
        checks++; if (rand_cyc == 0) begin failures++; $display("FAIL stall_seen got=0 exp>0"); end
        checks++; if (ack_cnt - a0 != 100) begin failures++; $display("FAIL rs_acks got=%0d exp=100", ack_cnt - a0); end
        checks++; if (lat_errs != l0 || to_errs != t0) begin failures++; $display("FAIL rs_latency got=%0d exp=0", lat_errs - l0 + to_errs - t0); end
        checks++; if (stream_diffs() != 0) begin failures++; $display("FAIL rs_stream got=%0d beats exp=%0d", rx_q.size(), exp_q.size()); end
        checks++; if (lb !== 16'd100 || on_time !== 1'b1) begin failures++; $display("FAIL rs_last_beats got=%0d eof=%0b exp=100 eof=1", lb, on_time); end
    endtask

    task automatic test_backpressure();
        int a0 = 0, l0;
        bit hold_bad = 0;
        bit early, on_time;
        logic [15:0] lb, d0;
        logic [31:0] fc;
        stall_en = 1'b0;
        exp_q.delete(); rx_q.delete();
        l0 = lat_errs;
        out_ready = 1'b0;
        open_frame();
        d0 = 16'($urandom);
        drive_beat(1'b1, c_WRF_DATA, 2'b11, d0);
        snk.stb_i = 1'b1; snk.we_i = 1'b1;
        snk.dat_i = ~d0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (i == 0) a0 = ack_cnt;
            if (snk.stall_o !== 1'b1 || out_dat !== d0 || out_valid !== 1'b1)
                hold_bad = 1;
        end
        checks++; if (hold_bad) begin failures++; $display("FAIL bp_hold got stall=%0b dat=%0h exp stall=1 dat=%0h", snk.stall_o, out_dat, d0); end
        checks++; if (ack_cnt != a0) begin failures++; $display("FAIL bp_no_ack got=%0d exp=0", ack_cnt - a0); end
        tick();
        out_ready = 1'b1;
        drive_beat(1'b1, c_WRF_DATA, 2'b11, ~d0);
        for (int i = 0; i < 8; i++) rand_write();
        close_frame(early, on_time, lb, fc);
        flush();
        checks++; if (stream_diffs() != 0) begin failures++; $display("FAIL bp_stream got=%0d beats exp=%0d", rx_q.size(), exp_q.size()); end
        checks++; if (lb !== 16'd10 || lat_errs != l0) begin failures++; $display("FAIL bp_beats got=%0d lat=%0d exp=10 lat=0", lb, lat_errs - l0); end
    endtask

    task automatic test_read_beat();
        int a0, r0, l0;
        bit early, on_time;
        logic [15:0] lb;
        logic [31:0] fc;
        stall_en = 1'b0; out_ready = 1'b1;
        exp_q.delete(); rx_q.delete();
        a0 = ack_cnt; r0 = err_cnt; l0 = lat_errs;
        open_frame();
        drive_beat(1'b0, c_WRF_DATA, 2'b11, 16'h1234);
        rand_write();
        drive_beat(1'b0, c_WRF_DATA, 2'b01, 16'h5678);
        rand_write();
        close_frame(early, on_time, lb, fc);
        flush();
        checks++; if (err_cnt - r0 != 2) begin failures++; $display("FAIL rd_err got=%0d exp=2", err_cnt - r0); end
        checks++; if (ack_cnt - a0 != 2) begin failures++; $display("FAIL rd_ack got=%0d exp=2", ack_cnt - a0); end
        checks++; if (lat_errs != l0) begin failures++; $display("FAIL rd_latency got=%0d exp=0", lat_errs - l0); end
        checks++; if (stream_diffs() != 0) begin failures++; $display("FAIL rd_stream got=%0d beats exp=%0d", rx_q.size(), exp_q.size()); end
        checks++; if (lb !== 16'd2 || fc !== 32'(exp_frames)) begin failures++; $display("FAIL rd_counts got lb=%0d fc=%0d exp lb=2 fc=%0d", lb, fc, exp_frames); end
    endtask

    task automatic test_empty_frame();
        int a0, e0;
        bit early, on_time;
        logic [15:0] lb;
        logic [31:0] fc;
        rx_q.delete();
        a0 = ack_cnt;
        open_frame();
        repeat (3) tick();
        close_frame(early, on_time, lb, fc);
        checks++; if (on_time !== 1'b1 || lb !== 16'd0) begin failures++; $display("FAIL empty_eof got eof=%0b lb=%0d exp eof=1 lb=0", on_time, lb); end
        checks++; if (fc !== 32'(exp_frames)) begin failures++; $display("FAIL empty_frame_cnt got=%0d exp=%0d", fc, exp_frames); end
        e0 = eof_cnt;
        snk.cyc_i = 1'b1;
        repeat (2) tick();
        snk.cyc_i = 1'b0; snk.stb_i = 1'b1; snk.we_i = 1'b1;
        repeat (2) tick();
        snk.stb_i = 1'b0;
        exp_frames++;
        repeat (3) tick();
        checks++; if (ack_cnt != a0 || rx_q.size() != 0) begin failures++; $display("FAIL stb_no_cyc got acks=%0d beats=%0d exp 0/0", ack_cnt - a0, rx_q.size()); end
        checks++; if (eof_cnt - e0 != 1 || last_beats !== 16'd0 || frame_cnt !== 32'(exp_frames)) begin failures++; $display("FAIL fall_stb got eofs=%0d lb=%0d fc=%0d exp 1/0/%0d", eof_cnt - e0, last_beats, frame_cnt, exp_frames); end
    endtask

    task automatic test_mixed_random();
        int a0, r0, l0, t0, nwr, nrd, bad_lb;
        bit early, on_time;
        logic [15:0] lb;
        logic [31:0] fc;
        exp_q.delete(); rx_q.delete();
        a0 = ack_cnt; r0 = err_cnt; l0 = lat_errs; t0 = to_errs;
        nwr = 0; nrd = 0; bad_lb = 0;
        stall_en = 1'b1;
        stall_thresh = 8'($urandom_range(0, 200));
        rand_ready_en = 1;
        for (int f = 0; f < 3; f++) begin
            open_frame();
            for (int b = 0; b < int'($urandom_range(5, 20)); b++) begin
                if ($urandom_range(0, 4) == 0) begin
                    drive_beat(1'b0, 2'($urandom_range(0, 3)), 2'b11, 16'($urandom));
                    nrd++;
                end else begin
                    rand_write();
                    nwr++;
                end
                repeat ($urandom_range(0, 2)) tick();
            end
            close_frame(early, on_time, lb, fc);
            if (lb !== 16'(exp_beats) || on_time !== 1'b1 || fc !== 32'(exp_frames)) bad_lb++;
        end
        rand_ready_en = 0;
        repeat (2) tick();
        stall_en = 1'b0;
        flush();
        checks++; if (bad_lb != 0) begin failures++; $display("FAIL mix_frames got=%0d bad exp=0", bad_lb); end
        checks++; if (ack_cnt - a0 != nwr || err_cnt - r0 != nrd) begin failures++; $display("FAIL mix_replies got ack=%0d err=%0d exp ack=%0d err=%0d", ack_cnt - a0, err_cnt - r0, nwr, nrd); end
        checks++; if (lat_errs != l0 || to_errs != t0) begin failures++; $display("FAIL mix_latency got=%0d exp=0", lat_errs - l0 + to_errs - t0); end
        checks++; if (stream_diffs() != 0) begin failures++; $display("FAIL mix_stream got=%0d beats exp=%0d", rx_q.size(), exp_q.size()); end
    endtask

    task automatic test_reset_mid_frame();
        int e0;
        bit early, on_time;
        logic [15:0] lb;
        logic [31:0] fc;
        stall_en = 1'b0; out_ready = 1'b1;
        open_frame();
        for (int i = 0; i < 10; i++) rand_write();
        e0 = eof_cnt;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || snk.ack_o !== 1'b0 || snk.stall_o !== 1'b0) begin failures++; $display("FAIL mid_rst_bus got v=%0b a=%0b s=%0b exp 000", out_valid, snk.ack_o, snk.stall_o); end
        checks++; if (last_beats !== 16'd0 || frame_cnt !== 32'd0 || eof !== 1'b0) begin failures++; $display("FAIL mid_rst_cnt got lb=%0d fc=%0d eof=%0b exp 0/0/0", last_beats, frame_cnt, eof); end
        checks++; if (out_dat !== 16'd0 || out_sof !== 1'b0) begin failures++; $display("FAIL mid_rst_data got dat=%0h sof=%0b exp 0/0", out_dat, out_sof); end
        repeat (2) tick();
        snk.cyc_i = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        checks++; if (eof_cnt != e0) begin failures++; $display("FAIL mid_rst_no_eof got=%0d exp=0", eof_cnt - e0); end
        exp_frames = 0;
        exp_q.delete(); rx_q.delete();
        open_frame();
        for (int i = 0; i < 3; i++) rand_write();
        close_frame(early, on_time, lb, fc);
        flush();
        checks++; if (stream_diffs() != 0 || rx_q.size() == 0 || rx_q[0].sof !== 1'b1) begin failures++; $display("FAIL post_rst_stream got=%0d beats exp=%0d with sof", rx_q.size(), exp_q.size()); end
        checks++; if (lb !== 16'd3 || fc !== 32'd1 || on_time !== 1'b1) begin failures++; $display("FAIL post_rst_counts got lb=%0d fc=%0d exp 3/1", lb, fc); end
    endtask

    initial begin
        snk.cyc_i = 1'b0; snk.stb_i = 1'b0; snk.we_i = 1'b0;
        snk.sel_i = 2'b00; snk.adr_i = 2'b00; snk.dat_i = 16'h0;
        test_reset();
        test_back_to_back();
        test_random_stall();
        test_backpressure();
        test_read_beat();
        test_empty_frame();
        test_mixed_random();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
